// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit: tracks in-flight writers over DEPTH post-issue stages.
// Latency: fwd_sel/src_data/stall are combinational (zero cycle) from tracked state and src inputs.
// Backpressure: stall or hold deasserts issue_ack; a stall shifts a bubble into stage 1, hold freezes all.
//
// Ports: clk/rst_n (synchronous active-low reset); issue_* describe the instruction at issue;
//   src_addr/src_use/src_rfdata give per-operand register address, use flag and regfile data;
//   stage_wdata carries the result held in stage k (slice k-1); hold freezes, flush kills writers;
//   fwd_sel/src_data give per-operand select (0 = regfile, k = stage k) and resolved data;
//   stall and issue_ack gate the issue stage.
// Optional: define FWD_STATS_EN to add stat_stall/stat_fwd saturating 32-bit event counters.
module fwd_scoreboard #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic                    issue_we,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_load,
  input  logic [NUM_SRC*5-1:0]    src_addr,
  input  logic [NUM_SRC-1:0]      src_use,
  input  logic [NUM_SRC*XLEN-1:0] src_rfdata,
  input  logic [DEPTH*XLEN-1:0]   stage_wdata,
  input  logic                    hold,
  input  logic                    flush,
  output logic [NUM_SRC*2-1:0]    fwd_sel,
  output logic [NUM_SRC*XLEN-1:0] src_data,
  output logic                    stall,
  output logic                    issue_ack
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]             stat_stall,
  output logic [31:0]             stat_fwd
`endif
);

  // The select field is 2 bits wide, so at most three stages can be named.
  generate
    if (DEPTH < 1 || DEPTH > 3) begin : g_bad_depth
      $error("fwd_scoreboard: DEPTH must be in 1..3");
    end
    if (LOAD_READY < 1 || LOAD_READY > DEPTH) begin : g_bad_load_ready
      $error("fwd_scoreboard: LOAD_READY must be in 1..DEPTH");
    end
  endgenerate

  // Tracked writer per stage; index 1 is the youngest (one cycle after issue).
  logic       v_q  [1:DEPTH];
  logic       we_q [1:DEPTH];
  logic [4:0] rd_q [1:DEPTH];
  logic       ld_q [1:DEPTH];

  logic            hit;
  logic [1:0]      hit_k;
  logic            hit_early;
  logic [XLEN-1:0] hit_data;
  logic            any_fwd;

  // Per operand, scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_sel   = '0;
    src_data  = src_rfdata;
    stall     = 1'b0;
    any_fwd   = 1'b0;
    hit       = 1'b0;
    hit_k     = 2'd0;
    hit_early = 1'b0;
    hit_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit       = 1'b0;
      hit_k     = 2'd0;
      hit_early = 1'b0;
      hit_data  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_use[i] && v_q[k] && we_q[k] &&
            (rd_q[k] == src_addr[i*5 +: 5]) && (rd_q[k] != 5'd0)) begin
          hit       = 1'b1;
          hit_k     = 2'(k);
          hit_early = ld_q[k] && (k < LOAD_READY);
          hit_data  = stage_wdata[(k-1)*XLEN +: XLEN];
        end
      end
      if (hit && hit_early) begin
        // Load data not yet on the bus: hold the consumer, report regfile select.
        stall = 1'b1;
      end else if (hit) begin
        fwd_sel[i*2 +: 2]     = hit_k;
        src_data[i*XLEN +: XLEN] = hit_data;
        any_fwd               = 1'b1;
      end
    end
  end

  assign issue_ack = issue_valid && !stall && !hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]  <= 1'b0;
        we_q[k] <= 1'b0;
        rd_q[k] <= 5'd0;
        ld_q[k] <= 1'b0;
      end
    end else if (flush) begin
      // Redirect: every tracked writer and any concurrent issue is dropped.
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k] <= 1'b0;
      end
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_q[k]  <= v_q[k-1];
        we_q[k] <= we_q[k-1];
        rd_q[k] <= rd_q[k-1];
        ld_q[k] <= ld_q[k-1];
      end
      // A stalled issue lands here as v=0, i.e. a bubble.
      v_q[1]  <= issue_ack;
      we_q[1] <= issue_we;
      rd_q[1] <= issue_rd;
      ld_q[1] <= issue_load;
    end
  end

`ifdef FWD_STATS_EN
  // Event counters survive flush; they only clear on reset and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
    end else begin
      if (stall && issue_valid && !hold && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (issue_ack && any_fwd && (stat_fwd != 32'hFFFF_FFFF)) begin
        stat_fwd <= stat_fwd + 32'd1;
      end
    end
  end
`endif

endmodule
